// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder scan controller.
package decoder_scan_pkg;

  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1 (minimum 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell counter: clears, freezes, and flags the last cycle of a timed dwell.
module scan_dwell_timer
  import decoder_scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_freeze,
  output logic o_tc_c
);

  localparam int unsigned CNT_W = clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (!i_freeze) begin
      r_count <= (r_count == LAST_CNT) ? '0 : r_count + 1'b1;
    end
  end

  assign o_tc_c = (r_count == LAST_CNT);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sweeps the 4-to-16 decoder select with break-before-make enable.
// Optional SCAN_DIR_EN adds a dir input for downward sweeps.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned LAST_INDEX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             step_mode,
  input  logic             step,
`ifdef SCAN_DIR_EN
  input  logic             dir,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAST_INDEX);

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_en;
  logic             r_busy;
  logic             r_wrap;
  logic             r_done;
  logic             r_oneshot;
  logic             r_down;

  logic             w_dir_start;
  logic             w_tc;
  logic             w_dwell_end;
  logic             w_at_end;
  logic [SEL_W-1:0] w_first_sel;
  logic [SEL_W-1:0] w_next_sel;

`ifdef SCAN_DIR_EN
  assign w_dir_start = dir;
`else
  assign w_dir_start = 1'b0;
`endif

  // Counter only runs inside DWELL; leaving DWELL always restarts it.
  scan_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state != S_DWELL),
    .i_freeze(step_mode),
    .o_tc_c  (w_tc)
  );

  assign w_dwell_end = step_mode ? step : w_tc;
  assign w_first_sel = w_dir_start ? LAST_SEL : '0;
  assign w_at_end    = (r_sel == (r_down ? '0 : LAST_SEL));
  assign w_next_sel  = w_at_end ? (r_down ? LAST_SEL : '0)
                                : (r_down ? r_sel - 1'b1 : r_sel + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
      r_oneshot <= 1'b0;
      r_down    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state   <= S_DWELL;
            r_sel     <= w_first_sel;
            r_en      <= 1'b1;
            r_busy    <= 1'b1;
            r_oneshot <= oneshot;
            r_down    <= w_dir_start;
          end
        end
        S_DWELL: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_dwell_end) begin
            r_state <= S_BLANK;
            r_en    <= 1'b0;
            r_wrap  <= w_at_end;
          end
        end
        S_BLANK: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_at_end && r_oneshot) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_DWELL;
            r_en    <= 1'b1;
            r_sel   <= w_next_sel;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = r_sel;
  assign en   = r_en;
  assign busy = r_busy;
  assign wrap = r_wrap;
  assign done = r_done;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl; observed vector is {sel,en,busy,wrap,done}.
module tb_decoder_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stop, oneshot, step_mode, step, start0, start1;
`ifdef SCAN_DIR_EN
  logic dir;
`endif
  logic [3:0] sel0, sel1;
  logic en0, busy0, wrap0, done0;
  logic en1, busy1, wrap1, done1;
  logic [7:0] obs0, obs1;

  int total = 0;
  int bad   = 0;

  assign obs0 = {sel0, en0, busy0, wrap0, done0};
  assign obs1 = {sel1, en1, busy1, wrap1, done1};

  decoder_scan_ctrl #(.DWELL_CYCLES(4), .LAST_INDEX(15)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop), .oneshot(oneshot),
    .step_mode(step_mode), .step(step),
`ifdef SCAN_DIR_EN
    .dir(dir),
`endif
    .sel(sel0), .en(en0), .busy(busy0), .wrap(wrap0), .done(done0)
  );

  decoder_scan_ctrl #(.DWELL_CYCLES(2), .LAST_INDEX(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop), .oneshot(oneshot),
    .step_mode(step_mode), .step(step),
`ifdef SCAN_DIR_EN
    .dir(1'b0),
`endif
    .sel(sel1), .en(en1), .busy(busy1), .wrap(wrap1), .done(done1)
  );

  function automatic logic [7:0] ev(input int s, input bit e, input bit b,
                                    input bit w, input bit d);
    return {4'(s), e, b, w, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stop = 0; oneshot = 0; step_mode = 0; step = 0;
    start0 = 0; start1 = 0;
`ifdef SCAN_DIR_EN
    dir = 0;
`endif
    tick(); tick();
    total++;
    if (obs0 !== 8'h00) begin bad++; $display("FAIL reset0 got=%h exp=00", obs0); end
    total++;
    if (obs1 !== 8'h00) begin bad++; $display("FAIL reset1 got=%h exp=00", obs1); end
    rst = 1'b0;
    tick();
    total++;
    if (obs0 !== 8'h00) begin bad++; $display("FAIL idle_after_reset got=%h exp=00", obs0); end
  endtask

  // Continuous sweep, defaults: code k dwells 4 cycles then blanks 1; wrap at code 15's blank.
  task automatic test_continuous();
    logic [7:0] exp;
    int m;
    oneshot = 0;
    start0 = 1; tick(); start0 = 0;
    total++;
    if (obs0 !== ev(0, 1, 1, 0, 0)) begin bad++; $display("FAIL cont_start got=%h exp=%h", obs0, ev(0, 1, 1, 0, 0)); end
    for (int n = 1; n <= 160; n++) begin
      tick();
      m = n % 80;
      exp = ev(m / 5, (m % 5) != 4, 1, m == 79, 0);
      total++;
      if (obs0 !== exp) begin bad++; $display("FAIL cont n=%0d got=%h exp=%h", n, obs0, exp); end
    end
  endtask

  task automatic test_stop_start();
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (sel0 == 4'd6 && en0 == 1'b1) found = 1;
      else tick();
    end
    total++;
    if (!found) begin bad++; $display("FAIL stop_reach got=%h exp=sel 6 dwell", obs0); end
    stop = 1; start0 = 1; tick(); stop = 0; start0 = 0;
    total++;
    if (obs0 !== ev(6, 0, 0, 0, 0)) begin bad++; $display("FAIL stop got=%h exp=%h", obs0, ev(6, 0, 0, 0, 0)); end
    tick(); tick();
    total++;
    if (obs0 !== ev(6, 0, 0, 0, 0)) begin bad++; $display("FAIL stop_hold got=%h exp=%h", obs0, ev(6, 0, 0, 0, 0)); end
    start0 = 1; tick(); start0 = 0;
    total++;
    if (obs0 !== ev(0, 1, 1, 0, 0)) begin bad++; $display("FAIL restart got=%h exp=%h", obs0, ev(0, 1, 1, 0, 0)); end
    stop = 1; tick(); stop = 0;
    total++;
    if (obs0 !== ev(0, 0, 0, 0, 0)) begin bad++; $display("FAIL stop2 got=%h exp=%h", obs0, ev(0, 0, 0, 0, 0)); end
  endtask

  task automatic test_step();
    step_mode = 1;
    start0 = 1; tick(); start0 = 0;
    for (int s = 1; s <= 3; s++) begin
      for (int i = 0; i < 9; i++) begin
        tick();
        total++;
        if (obs0 !== ev(s - 1, 1, 1, 0, 0)) begin bad++; $display("FAIL step_hold s=%0d got=%h exp=%h", s, obs0, ev(s - 1, 1, 1, 0, 0)); end
      end
      step = 1; tick(); step = 0;
      total++;
      if (obs0 !== ev(s - 1, 0, 1, 0, 0)) begin bad++; $display("FAIL step_blank s=%0d got=%h exp=%h", s, obs0, ev(s - 1, 0, 1, 0, 0)); end
      tick();
      total++;
      if (obs0 !== ev(s, 1, 1, 0, 0)) begin bad++; $display("FAIL step_adv s=%0d got=%h exp=%h", s, obs0, ev(s, 1, 1, 0, 0)); end
    end
    // Timed dwell resumes from a frozen count rather than restarting.
    step_mode = 0; tick(); tick();
    step_mode = 1;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (obs0 !== ev(3, 1, 1, 0, 0)) begin bad++; $display("FAIL freeze got=%h exp=%h", obs0, ev(3, 1, 1, 0, 0)); end
    step_mode = 0; tick();
    total++;
    if (obs0 !== ev(3, 1, 1, 0, 0)) begin bad++; $display("FAIL resume_dwell got=%h exp=%h", obs0, ev(3, 1, 1, 0, 0)); end
    tick();
    total++;
    if (obs0 !== ev(3, 0, 1, 0, 0)) begin bad++; $display("FAIL resume_blank got=%h exp=%h", obs0, ev(3, 0, 1, 0, 0)); end
    stop = 1; tick(); stop = 0;
  endtask

  // LAST_INDEX=3, DWELL_CYCLES=2: 3-cycle period per code, done 12 edges after start.
  task automatic test_oneshot();
    logic [7:0] exp;
    oneshot = 1;
    start1 = 1; tick(); start1 = 0; oneshot = 0;
    total++;
    if (obs1 !== ev(0, 1, 1, 0, 0)) begin bad++; $display("FAIL os_start got=%h exp=%h", obs1, ev(0, 1, 1, 0, 0)); end
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n < 12)       exp = ev(n / 3, (n % 3) != 2, 1, n == 11, 0);
      else if (n == 12) exp = ev(3, 0, 0, 0, 1);
      else              exp = ev(3, 0, 0, 0, 0);
      total++;
      if (obs1 !== exp) begin bad++; $display("FAIL oneshot n=%0d got=%h exp=%h", n, obs1, exp); end
    end
  endtask

`ifdef SCAN_DIR_EN
  task automatic test_dir();
    logic [7:0] exp;
    int m;
    oneshot = 0; dir = 1;
    start0 = 1; tick(); start0 = 0; dir = 0;
    total++;
    if (obs0 !== ev(15, 1, 1, 0, 0)) begin bad++; $display("FAIL dir_start got=%h exp=%h", obs0, ev(15, 1, 1, 0, 0)); end
    for (int n = 1; n <= 85; n++) begin
      tick();
      m = n % 80;
      exp = ev(15 - m / 5, (m % 5) != 4, 1, m == 79, 0);
      total++;
      if (obs0 !== exp) begin bad++; $display("FAIL dir n=%0d got=%h exp=%h", n, obs0, exp); end
    end
    stop = 1; tick(); stop = 0;
  endtask
`endif

  task automatic test_async_reset();
    bit found = 0;
    step_mode = 0; oneshot = 0;
    start0 = 1; tick(); start0 = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (sel0 == 4'd9 && en0 == 1'b0) found = 1;
      else tick();
    end
    total++;
    if (!found || obs0 !== ev(9, 0, 1, 0, 0)) begin bad++; $display("FAIL arst_reach got=%h exp=%h", obs0, ev(9, 0, 1, 0, 0)); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs0 !== 8'h00) begin bad++; $display("FAIL arst got=%h exp=00", obs0); end
    tick();
    total++;
    if (obs0 !== 8'h00) begin bad++; $display("FAIL arst_hold got=%h exp=00", obs0); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_stop_start();
    test_step();
    test_oneshot();
`ifdef SCAN_DIR_EN
    test_dir();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
